// File: rtl/alu_redirect_gen_pkg.sv
// Shared types and age helpers for the ALU redirect generator.
// Pointers carry a wrap flag on top of the ring index.
package alu_redirect_gen_pkg;

  localparam int NUM_SRC = 2;
  localparam int ROB_W   = 5;
  localparam int FTQ_W   = 3;
  localparam int OFF_W   = 3;
  localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic FLUSH_AFTER  = 1'b0;
  localparam logic FLUSH_ITSELF = 1'b1;

  typedef struct packed {
    logic             flag;
    logic [ROB_W-1:0] value;
  } rob_ptr_t;

  typedef struct packed {
    logic             flag;
    logic [FTQ_W-1:0] value;
  } ftq_ptr_t;

  typedef struct packed {
    rob_ptr_t         rob;
    ftq_ptr_t         ftq;
    logic [OFF_W-1:0] off;
    logic             taken;
    logic [SRC_W-1:0] src;
  } redirect_t;

  function automatic logic is_after(
    input rob_ptr_t a,
    input rob_ptr_t b
  );
    return (a.flag ^ b.flag) ^ (a.value > b.value);
  endfunction

  function automatic logic is_equal(
    input rob_ptr_t a,
    input rob_ptr_t b
  );
    return (a.flag == b.flag) && (a.value == b.value);
  endfunction

  function automatic logic flush_kill(
    input rob_ptr_t x,
    input logic     fv,
    input rob_ptr_t f,
    input logic     lvl
  );
    return fv && (is_after(x, f) ||
      ((lvl == FLUSH_ITSELF) && is_equal(x, f)));
  endfunction

endpackage

// File: rtl/alu_redirect_gen_oldest_sel.sv
// Oldest-by-ROB-order selector over the redirect candidates.
// Returns a one-hot winner vector and its index.
module redirect_oldest_sel
  import alu_redirect_gen_pkg::*;
(
  input  logic [NUM_SRC-1:0] cand_i,
  input  rob_ptr_t           rob_i [NUM_SRC],
  output logic [NUM_SRC-1:0] onehot_o,
  output logic [SRC_W-1:0]   idx_o
);

  // i wins unless some other candidate beats it;
  // equal or mutually-after pairs go to the lower index
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      onehot_o[i] = cand_i[i];
      for (int j = 0; j < NUM_SRC; j++) begin
        if (j < i) begin
          if (cand_i[j] && !is_after(rob_i[j], rob_i[i]))
            onehot_o[i] = 1'b0;
        end else if (j > i) begin
          if (cand_i[j] && is_after(rob_i[i], rob_i[j]) &&
              !is_after(rob_i[j], rob_i[i]))
            onehot_o[i] = 1'b0;
        end
      end
    end
  end

  // encode the winner position
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (onehot_o[i]) idx_o = idx_o | SRC_W'(i);
    end
  end

endmodule

// File: rtl/alu_redirect_gen.sv
// Filters ALU mispredict redirects, picks the oldest survivor
// and registers it for one-cycle delivery to the FTQ.
module alu_redirect_gen
  import alu_redirect_gen_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       in_valid,
  input  logic [NUM_SRC-1:0]       in_isMisPred,
  input  logic [NUM_SRC-1:0]       in_taken,
  input  logic [NUM_SRC-1:0]       in_robIdx_flag,
  input  logic [NUM_SRC*ROB_W-1:0] in_robIdx_value,
  input  logic [NUM_SRC-1:0]       in_ftqIdx_flag,
  input  logic [NUM_SRC*FTQ_W-1:0] in_ftqIdx_value,
  input  logic [NUM_SRC*OFF_W-1:0] in_ftqOffset,
  input  logic                     flush_valid,
  input  logic                     flush_robIdx_flag,
  input  logic [ROB_W-1:0]         flush_robIdx_value,
  input  logic                     flush_level,
  output logic                     out_valid,
  output logic                     out_robIdx_flag,
  output logic [ROB_W-1:0]         out_robIdx_value,
  output logic                     out_ftqIdx_flag,
  output logic [FTQ_W-1:0]         out_ftqIdx_value,
  output logic [OFF_W-1:0]         out_ftqOffset,
  output logic                     out_taken,
  output logic [SRC_W-1:0]         out_src
);

  rob_ptr_t           flush_ptr;
  rob_ptr_t           rob  [NUM_SRC];
  redirect_t          req  [NUM_SRC];
  redirect_t          sel;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] win;
  logic [SRC_W-1:0]   win_idx;
  logic               s1_kill;

  redirect_t s1_q, s1_d;
  logic      s1_v_q, s1_v_d;
  rob_ptr_t  last_q, last_d;
  logic      last_v_q, last_v_d;

  // unpack sources and qualify each as a candidate
  always_comb begin
    flush_ptr.flag  = flush_robIdx_flag;
    flush_ptr.value = flush_robIdx_value;
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i].rob.flag  = in_robIdx_flag[i];
      req[i].rob.value = in_robIdx_value[i*ROB_W +: ROB_W];
      req[i].ftq.flag  = in_ftqIdx_flag[i];
      req[i].ftq.value = in_ftqIdx_value[i*FTQ_W +: FTQ_W];
      req[i].off       = in_ftqOffset[i*OFF_W +: OFF_W];
      req[i].taken     = in_taken[i];
      req[i].src       = SRC_W'(i);
      rob[i]           = req[i].rob;
      cand[i] = in_valid[i] && in_isMisPred[i] &&
        !flush_kill(rob[i], flush_valid, flush_ptr, flush_level) &&
        !(last_v_q && (is_after(rob[i], last_q) ||
                       is_equal(rob[i], last_q)));
    end
  end

  redirect_oldest_sel u_sel (
    .cand_i   (cand),
    .rob_i    (rob),
    .onehot_o (win),
    .idx_o    (win_idx)
  );

  // one-hot payload mux plus kill of the registered redirect
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win[i]) sel = req[i];
    end
    sel.src   = win_idx;
    s1_kill   = flush_kill(s1_q.rob, flush_valid, flush_ptr, flush_level);
    out_valid = s1_v_q && !s1_kill;
  end

  // next state: new winner loads s1, emitted redirect updates last
  always_comb begin
    s1_v_d   = |cand;
    s1_d     = (|cand) ? sel : s1_q;
    last_v_d = last_v_q;
    last_d   = last_q;
    if (out_valid) begin
      last_v_d = 1'b1;
      last_d   = s1_q.rob;
    end else if (flush_valid) begin
      last_v_d = 1'b0;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v_q   <= 1'b0;
      s1_q     <= '0;
      last_v_q <= 1'b0;
      last_q   <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_q     <= s1_d;
      last_v_q <= last_v_d;
      last_q   <= last_d;
    end
  end

  assign out_robIdx_flag  = s1_q.rob.flag;
  assign out_robIdx_value = s1_q.rob.value;
  assign out_ftqIdx_flag  = s1_q.ftq.flag;
  assign out_ftqIdx_value = s1_q.ftq.value;
  assign out_ftqOffset    = s1_q.off;
  assign out_taken        = s1_q.taken;
  assign out_src          = s1_q.src;

endmodule

// File: tb/tb_alu_redirect_gen.sv
// Directed table plus randomized model check
// for alu_redirect_gen.
module tb_alu_redirect_gen;
  import alu_redirect_gen_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] in_valid, in_isMisPred, in_taken;
  logic [1:0] in_robIdx_flag, in_ftqIdx_flag;
  logic [9:0] in_robIdx_value;
  logic [5:0] in_ftqIdx_value, in_ftqOffset;
  logic       flush_valid, flush_robIdx_flag, flush_level;
  logic [4:0] flush_robIdx_value;
  logic       out_valid, out_robIdx_flag, out_ftqIdx_flag;
  logic [4:0] out_robIdx_value;
  logic [2:0] out_ftqIdx_value, out_ftqOffset;
  logic       out_taken;
  logic [0:0] out_src;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_redirect_gen dut (
    .clock              (clock),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_isMisPred       (in_isMisPred),
    .in_taken           (in_taken),
    .in_robIdx_flag     (in_robIdx_flag),
    .in_robIdx_value    (in_robIdx_value),
    .in_ftqIdx_flag     (in_ftqIdx_flag),
    .in_ftqIdx_value    (in_ftqIdx_value),
    .in_ftqOffset       (in_ftqOffset),
    .flush_valid        (flush_valid),
    .flush_robIdx_flag  (flush_robIdx_flag),
    .flush_robIdx_value (flush_robIdx_value),
    .flush_level        (flush_level),
    .out_valid          (out_valid),
    .out_robIdx_flag    (out_robIdx_flag),
    .out_robIdx_value   (out_robIdx_value),
    .out_ftqIdx_flag    (out_ftqIdx_flag),
    .out_ftqIdx_value   (out_ftqIdx_value),
    .out_ftqOffset      (out_ftqOffset),
    .out_taken          (out_taken),
    .out_src            (out_src)
  );

  typedef struct {
    logic [1:0] v, mp, tk;
    logic [5:0] r0, r1;
    logic [3:0] f0, f1;
    logic [2:0] o0, o1;
    logic       fv;
    logic [5:0] fr;
    logic       fl;
    logic       ev;
    logic [5:0] er;
    logic [3:0] ef;
    logic [2:0] eo;
    logic       et, es;
  } vec_t;

  vec_t rows[$];

  function automatic vec_t mk(
    input logic [1:0] v, mp, tk,
    input logic [5:0] r0, r1,
    input logic [3:0] f0, f1,
    input logic [2:0] o0, o1,
    input logic fv,
    input logic [5:0] fr,
    input logic fl
  );
    vec_t x;
    x.v = v; x.mp = mp; x.tk = tk;
    x.r0 = r0; x.r1 = r1;
    x.f0 = f0; x.f1 = f1;
    x.o0 = o0; x.o1 = o1;
    x.fv = fv; x.fr = fr; x.fl = fl;
    x.ev = 1'b0; x.er = '0; x.ef = '0;
    x.eo = '0; x.et = 1'b0; x.es = 1'b0;
    return x;
  endfunction

  function automatic vec_t ex(
    input vec_t b,
    input logic [5:0] er,
    input logic [3:0] ef,
    input logic [2:0] eo,
    input logic et, es
  );
    vec_t x = b;
    x.ev = 1'b1; x.er = er; x.ef = ef;
    x.eo = eo; x.et = et; x.es = es;
    return x;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic rst,
    input logic [1:0] v, mp, tk,
    input logic [5:0] r0, r1,
    input logic [3:0] f0, f1,
    input logic [2:0] o0, o1,
    input logic fv,
    input logic [5:0] fr,
    input logic fl
  );
    reset              = rst;
    in_valid           = v;
    in_isMisPred       = mp;
    in_taken           = tk;
    in_robIdx_flag     = {r1[5], r0[5]};
    in_robIdx_value    = {r1[4:0], r0[4:0]};
    in_ftqIdx_flag     = {f1[3], f0[3]};
    in_ftqIdx_value    = {f1[2:0], f0[2:0]};
    in_ftqOffset       = {o1, o0};
    flush_valid        = fv;
    flush_robIdx_flag  = fr[5];
    flush_robIdx_value = fr[4:0];
    flush_level        = fl;
  endtask

  task automatic cyc(
    input logic rst,
    input logic [1:0] v, mp, tk,
    input logic [5:0] r0, r1,
    input logic [3:0] f0, f1,
    input logic [2:0] o0, o1,
    input logic fv,
    input logic [5:0] fr,
    input logic fl
  );
    @(posedge clock);
    #1;
    drive(rst, v, mp, tk, r0, r1, f0, f1, o0, o1, fv, fr, fl);
    @(negedge clock);
  endtask

  function automatic logic [5:0] orob();
    return {out_robIdx_flag, out_robIdx_value};
  endfunction

  function automatic logic [3:0] oftq();
    return {out_ftqIdx_flag, out_ftqIdx_value};
  endfunction

  // ring age: a is younger than b when it sits 1..32 slots ahead
  function automatic bit m_after(input logic [5:0] a, b);
    logic [5:0] d;
    d = a - b;
    return (d >= 6'd1) && (d <= 6'd32);
  endfunction

  function automatic bit m_kill(
    input logic [5:0] x,
    input logic fv,
    input logic [5:0] fr,
    input logic fl
  );
    return fv && (m_after(x, fr) || (fl && x == fr));
  endfunction

  bit         m_s1v, m_lastv;
  logic [5:0] m_rob, m_last;
  logic [3:0] m_ftq;
  logic [2:0] m_off;
  logic       m_tk, m_src;

  vec_t idle, flclr;

  initial begin
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    flclr = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'h3F, 0);

    // single source
    rows.push_back(mk(2'b01, 2'b01, 2'b01, 6'h05, 0,
                      4'hA, 0, 3'd3, 0, 0, 0, 0));
    rows.push_back(ex(idle, 6'h05, 4'hA, 3'd3, 1, 0));
    // two sources, older wins; younger follower dropped
    rows.push_back(flclr);
    rows.push_back(mk(2'b11, 2'b11, 2'b10, 6'h22, 6'h1E,
                      4'h1, 4'h7, 3'd1, 3'd6, 0, 0, 0));
    rows.push_back(ex(idle, 6'h1E, 4'h7, 3'd6, 1, 1));
    rows.push_back(mk(2'b01, 2'b01, 2'b00, 6'h1F, 0,
                      4'h2, 0, 3'd2, 0, 0, 0, 0));
    rows.push_back(idle);
    // wrap flag ordering
    rows.push_back(flclr);
    rows.push_back(mk(2'b11, 2'b11, 2'b00, 6'h21, 6'h1F,
                      4'h2, 4'h3, 3'd4, 3'd5, 0, 0, 0));
    rows.push_back(ex(idle, 6'h1F, 4'h3, 3'd5, 0, 1));
    // flush kills of the registered redirect
    rows.push_back(flclr);
    rows.push_back(mk(2'b01, 2'b01, 2'b01, 6'h0A, 0,
                      4'h4, 0, 3'd2, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'h08, 0));
    rows.push_back(mk(2'b01, 2'b01, 2'b01, 6'h0A, 0,
                      4'h4, 0, 3'd2, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'h0A, 1));
    rows.push_back(mk(2'b01, 2'b01, 2'b01, 6'h0A, 0,
                      4'h4, 0, 3'd2, 0, 0, 0, 0));
    rows.push_back(ex(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'h0A, 0),
                      6'h0A, 4'h4, 3'd2, 1, 0));
    // younger than last dropped, older accepted
    rows.push_back(mk(2'b01, 2'b01, 2'b00, 6'h0B, 0,
                      4'h5, 0, 3'd7, 0, 0, 0, 0));
    rows.push_back(mk(2'b10, 2'b10, 2'b00, 0, 6'h09,
                      0, 4'h5, 0, 3'd1, 0, 0, 0));
    rows.push_back(ex(idle, 6'h09, 4'h5, 3'd1, 0, 1));
    // valid without mispredict
    rows.push_back(flclr);
    rows.push_back(mk(2'b11, 2'b00, 2'b11, 6'h03, 6'h04,
                      4'h1, 4'h2, 3'd1, 3'd2, 0, 0, 0));
    rows.push_back(mk(2'b11, 2'b00, 2'b11, 6'h03, 6'h04,
                      4'h1, 4'h2, 3'd1, 3'd2, 0, 0, 0));
    rows.push_back(idle);

    // reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst valid", 32'(out_valid), 0);
    chk("rst rob", 32'(orob()), 0);
    chk("rst ftq", 32'(oftq()), 0);
    chk("rst off", 32'(out_ftqOffset), 0);
    chk("rst taken", 32'(out_taken), 0);
    chk("rst src", 32'(out_src), 0);

    for (int k = 0; k < rows.size(); k++) begin
      vec_t r;
      r = rows[k];
      cyc(0, r.v, r.mp, r.tk, r.r0, r.r1, r.f0, r.f1,
          r.o0, r.o1, r.fv, r.fr, r.fl);
      chk($sformatf("vec%0d valid", k), 32'(out_valid), 32'(r.ev));
      if (r.ev) begin
        chk($sformatf("vec%0d rob", k), 32'(orob()), 32'(r.er));
        chk($sformatf("vec%0d ftq", k), 32'(oftq()), 32'(r.ef));
        chk($sformatf("vec%0d off", k), 32'(out_ftqOffset), 32'(r.eo));
        chk($sformatf("vec%0d tk", k), 32'(out_taken), 32'(r.et));
        chk($sformatf("vec%0d src", k), 32'(out_src), 32'(r.es));
      end
    end

    // reset while a redirect is pending
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'h3F, 0);
    cyc(0, 2'b01, 2'b01, 0, 6'h0F, 0, 4'h1, 0, 3'd1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("seq first valid", 32'(out_valid), 1);
    chk("seq first rob", 32'(orob()), 32'h0F);
    cyc(0, 2'b01, 2'b01, 2'b01, 6'h0C, 0, 4'h2, 0, 3'd2, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("seq older valid", 32'(out_valid), 1);
    chk("seq older rob", 32'(orob()), 32'h0C);
    cyc(0, 2'b01, 2'b01, 0, 6'h14, 0, 4'h3, 0, 3'd4, 0, 0, 0, 0);
    chk("seq rst valid", 32'(out_valid), 0);
    chk("seq rst rob", 32'(orob()), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("seq young valid", 32'(out_valid), 1);
    chk("seq young rob", 32'(orob()), 32'h14);
    chk("seq young ftq", 32'(oftq()), 32'h3);
    chk("seq young off", 32'(out_ftqOffset), 32'h4);

    // randomized run against the model
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_s1v = 0; m_lastv = 0; m_rob = 0; m_last = 0;
    m_ftq = 0; m_off = 0; m_tk = 0; m_src = 0;
    for (int n = 0; n < 3000; n++) begin
      logic       rst, fv, fl, ev;
      logic [1:0] v, mp, tk;
      logic [5:0] r[2], fr;
      logic [3:0] f[2];
      logic [2:0] o[2];
      int         best;
      rst = ($urandom_range(0, 99) == 0);
      v   = 2'($urandom);
      mp  = 2'($urandom) | 2'($urandom);
      tk  = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        r[i] = 6'($urandom);
        f[i] = 4'($urandom);
        o[i] = 3'($urandom);
      end
      fv = ($urandom_range(0, 7) == 0);
      fr = 6'($urandom);
      fl = 1'($urandom);
      cyc(rst, v, mp, tk, r[0], r[1], f[0], f[1],
          o[0], o[1], fv, fr, fl);
      ev = m_s1v && !m_kill(m_rob, fv, fr, fl);
      chk("rnd valid", 32'(out_valid), 32'(ev));
      chk("rnd rob", 32'(orob()), 32'(m_rob));
      chk("rnd ftq", 32'(oftq()), 32'(m_ftq));
      chk("rnd off", 32'(out_ftqOffset), 32'(m_off));
      chk("rnd tk", 32'(out_taken), 32'(m_tk));
      chk("rnd src", 32'(out_src), 32'(m_src));
      if (rst) begin
        m_s1v = 0; m_lastv = 0; m_rob = 0; m_last = 0;
        m_ftq = 0; m_off = 0; m_tk = 0; m_src = 0;
      end else begin
        best = -1;
        for (int i = 0; i < 2; i++) begin
          if (v[i] && mp[i] && !m_kill(r[i], fv, fr, fl) &&
              !(m_lastv && (m_after(r[i], m_last) ||
                            r[i] == m_last))) begin
            if (best < 0)
              best = i;
            else if (m_after(r[best], r[i]) &&
                     !m_after(r[i], r[best]))
              best = i;
          end
        end
        if (ev) begin
          m_lastv = 1;
          m_last  = m_rob;
        end else if (fv) begin
          m_lastv = 0;
        end
        m_s1v = (best >= 0);
        if (best >= 0) begin
          m_rob = r[best];
          m_ftq = f[best];
          m_off = o[best];
          m_tk  = tk[best];
          m_src = 1'(best);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_redirect_gen.md
Name: alu_redirect_gen

Overview:
- Sits directly downstream of the ALU/branch execution units. Consumes their per-cycle redirect outputs: valid, robIdx, ftqIdx, ftqOffset, taken and isMisPred.
- Keeps only real mispredicts and drops any redirect already squashed by a backend flush or by an earlier self-generated redirect.
- Selects the oldest surviving redirect by ROB order and registers it.
- Emits one redirect per cycle towards the CtrlBlock/FTQ.

Parameters:
- NUM_SRC, 2, number of ALU redirect sources.
- ROB_W, 5, robIdx value width; a 1-bit wrap flag is added on top.
- FTQ_W, 3, ftqIdx value width; a 1-bit wrap flag is added on top.
- OFF_W, 3, ftqOffset width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_SRC  per-source redirectOutValid.
- in_isMisPred  in  NUM_SRC  per-source cfiUpdate.isMisPred.
- in_taken  in  NUM_SRC  per-source cfiUpdate.taken.
- in_robIdx_flag  in  NUM_SRC  per-source robIdx flag.
- in_robIdx_value  in  NUM_SRC*ROB_W  per-source robIdx value; source i occupies slice [i*ROB_W +: ROB_W].
- in_ftqIdx_flag  in  NUM_SRC  per-source ftqIdx flag.
- in_ftqIdx_value  in  NUM_SRC*FTQ_W  per-source ftqIdx value, packed as for robIdx.
- in_ftqOffset  in  NUM_SRC*OFF_W  per-source ftqOffset, packed as for robIdx.
- flush_valid  in  1  backend (ROB) flush this cycle.
- flush_robIdx_flag  in  1  flush robIdx flag.
- flush_robIdx_value  in  ROB_W  flush robIdx value.
- flush_level  in  1  0 = flush entries after robIdx; 1 = flush robIdx itself as well.
- out_valid  out  1  redirect valid.
- out_robIdx_flag  out  1  selected robIdx flag.
- out_robIdx_value  out  ROB_W  selected robIdx value.
- out_ftqIdx_flag  out  1  selected ftqIdx flag.
- out_ftqIdx_value  out  FTQ_W  selected ftqIdx value.
- out_ftqOffset  out  OFF_W  selected ftqOffset.
- out_taken  out  1  selected taken bit.
- out_src  out  clog2(NUM_SRC)  index of the winning source.

Behaviour:
- Age compare: isAfter(a,b) = (a.flag ^ b.flag) ^ (a.value > b.value). Same flag and same value means equal.
- Flush kill: flushKill(x) = flush_valid & (isAfter(x,flush) | (flush_level & x==flush)).
- Candidate i (cycle T) requires all of:
  - in_valid[i] & in_isMisPred[i];
  - !flushKill(in_i);
  - !(last_v & (isAfter(in_i,last) | in_i==last)).
- Selection: oldest candidate, i.e. the one no other candidate is older than. Ties on equal robIdx (illegal upstream) go to the lowest index.
- s1 register: at edge T→T+1, s1_v <= any candidate; the payload of the winner is captured. The payload is held when there is no candidate.
- s1 kill: s1_v is cleared at the edge if flushKill(s1) holds in cycle T. The new candidate load takes priority over this clear.
- Output, cycle T+1: out_valid = s1_v & !flushKill(s1); out_* = s1 payload, combinational from the register. Latency is 1 cycle, with no backpressure.
- last register (last_v, last robIdx) records the most recently emitted redirect:
  - When out_valid=1, last <= s1 robIdx and last_v <= 1. A younger redirect is never emitted after an older one already issued.
  - When flush_valid=1 and out_valid=0, last_v <= 0, since the global flush supersedes it.
  - When both hold, the out_valid update wins.
- Suppression: an input older than last is still accepted (it will redirect further back).
- Reset (synchronous) sets s1_v=0 and last_v=0. All payload registers reset to 0, so every output reads 0 after reset. Reset asserted mid-operation discards the pending s1 the next cycle.
- An input with in_valid=1 and in_isMisPred=0 is never a candidate.

Decomposition:
- Shared package holds:
  - RobPtr and FtqPtr typedefs (flag + value);
  - the isAfter/isEqual functions;
  - the redirect payload struct;
  - flush-level constants.
- One sub-module, redirect_oldest_sel: combinational NUM_SRC-way oldest-select returning a one-hot vector and the winning index. The top holds s1, last and the kill logic.

Test Plan:
1. reset, then a single source 0 with misPred, robIdx (0,5), ftq (1,2), off 3 → out_valid at the next cycle with robIdx (0,5), ftq (1,2), off 3, src 0.
2. Sources 0 = (1,2) and 1 = (0,30), both misPred, same cycle → out selects (0,30), src=1; a following input (0,31) is dropped because it is younger than last.
3. Wrap case: src0 (1,1), src1 (0,31) → (0,31) is older and wins.
4. Source (0,10) captured; next cycle flush (0,8) level 0 → out_valid=0, last_v stays 0; flush (0,10) level 1 also kills it.
5. valid=1 but isMisPred=0 on both sources → out_valid stays 0 for every cycle.
6. reset asserted while s1_v=1 → out_valid=0 on the next cycle and last_v=0; afterwards a young input (0,20) is accepted.
